// File: rtl/pq_host_adapter_if.sv
// pq_host_adapter_if: host push/pop/response handshakes plus the priority-queue side bus.
interface pq_host_adapter_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  i_push_valid;
    logic                  o_push_ready;
    logic [DATA_WIDTH-1:0] i_push_data;
    logic                  i_pop_valid;
    logic                  o_pop_ready;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_WIDTH-1:0] o_rsp_data;
    logic                  o_rsp_empty;
    logic                  o_pq_wrt;
    logic                  o_pq_read;
    logic [DATA_WIDTH-1:0] o_pq_data;
    logic                  i_pq_full;
    logic                  i_pq_empty;
    logic [DATA_WIDTH-1:0] i_pq_data;

    modport slave (
        input  i_push_valid, i_push_data, i_pop_valid, i_rsp_ready,
        input  i_pq_full, i_pq_empty, i_pq_data,
        output o_push_ready, o_pop_ready, o_rsp_valid, o_rsp_data, o_rsp_empty,
        output o_pq_wrt, o_pq_read, o_pq_data
    );

    modport master (
        output i_push_valid, i_push_data, i_pop_valid, i_rsp_ready,
        output i_pq_full, i_pq_empty, i_pq_data,
        input  o_push_ready, o_pop_ready, o_rsp_valid, o_rsp_data, o_rsp_empty,
        input  o_pq_wrt, o_pq_read, o_pq_data
    );
endinterface

// File: rtl/pq_host_adapter.sv
// pq_host_adapter: serialises host push/pop requests into single-cycle queue strobes with settle time.
module pq_host_adapter #(
    parameter int DATA_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input logic              i_CLK,
    input logic              i_RST,
    pq_host_adapter_if.slave pq
);
    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t                state_q;
    logic                  wrt_q;
    logic                  read_q;
    logic [DATA_WIDTH-1:0] pq_data_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_empty_q;
    logic [3:0]            cnt_q;
    logic                  pop_q;
    logic                  push_acc;
    logic                  pop_acc;

    // A replace (push+pop) never grows the queue, so it stays acceptable when full.
    assign pq.o_pop_ready  = !i_RST && state_q == IDLE;
    assign pq.o_push_ready = pq.o_pop_ready && (!pq.i_pq_full || pq.i_pop_valid);
    assign push_acc        = pq.i_push_valid && pq.o_push_ready;
    assign pop_acc         = pq.i_pop_valid && pq.o_pop_ready;

    assign pq.o_pq_wrt    = wrt_q;
    assign pq.o_pq_read   = read_q;
    assign pq.o_pq_data   = pq_data_q;
    assign pq.o_rsp_valid = rsp_valid_q;
    assign pq.o_rsp_data  = rsp_data_q;
    assign pq.o_rsp_empty = rsp_empty_q;

    // Command sequencer: accept, strobe one cycle, wait out the queue settle time, then respond.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= IDLE;
            wrt_q       <= 1'b0;
            read_q      <= 1'b0;
            pq_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_empty_q <= 1'b0;
            cnt_q       <= '0;
            pop_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push_acc || pop_acc) begin
                        state_q <= ISSUE;
                        pop_q   <= pop_acc;
                        wrt_q   <= push_acc;
                        read_q  <= pop_acc && (push_acc || !pq.i_pq_empty);
                        if (push_acc) pq_data_q <= pq.i_push_data;
                        if (pop_acc) begin
                            rsp_data_q  <= pq.i_pq_empty ? '0 : pq.i_pq_data;
                            rsp_empty_q <= pq.i_pq_empty;
                        end
                    end
                end
                ISSUE: begin
                    wrt_q   <= 1'b0;
                    read_q  <= 1'b0;
                    cnt_q   <= SETTLE_INIT;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == 4'd1) begin
                        cnt_q       <= '0;
                        state_q     <= pop_q ? RESP : IDLE;
                        rsp_valid_q <= pop_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (pq.i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        pop_q       <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
